pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and flow controller for the IF/ID stage register. It watches the decoded fields leaving IF/ID and the load in EX. From these it generates the IF_stall, IF_Flush, PC_Write and ID/EX bubble controls. It also tracks one in-flight multi-cycle FP multiply/divide, so dependent or conflicting FP instructions are held in ID until the result is ready.

## Interface
Parameters:
- FP_MUL_LAT, 4: busy cycles after a mul.s/mul.d issues (1..15).
- FP_DIV_LAT, 10: busy cycles after a div.s/div.d issues (1..15).

Ports:
- Clk  in  1  pipeline clock; all state updates on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- Op_code_ID  in  6  opcode held in IF/ID.
- Funct_ID  in  6  funct field held in IF/ID.
- Rs_ID  in  5  rs field held in IF/ID.
- Rt_ID  in  5  rt field; also used as Ft.
- Fs_ID  in  5  FP source field.
- Fd_ID  in  5  FP destination field.
- MemRead_EX  in  1  the instruction in EX is a load.
- Rt_EX  in  5  load destination register in EX.
- Branch_Taken  in  1  branch resolved taken in ID.
- Jump_ID  in  1  j/jal/jr in ID.
- IF_stall  out  1  hold IF/ID contents.
- IF_Flush  out  1  zero IF/ID on next edge.
- PC_Write  out  1  PC register load enable.
- ID_EX_Bubble  out  1  insert NOP control into ID/EX.
- FP_Busy  out  1  FP multi-cycle unit occupied.
- Stall_Cnt  out  16  saturating count of stall cycles.

## Operation
FP ops are decoded internally:
- An instruction is FP when Op_code_ID==6'h11.
- It is a mul when Funct_ID==6'h02 and a div when Funct_ID==6'h03.

Load-use hazard (combinational):
- Condition: MemRead_EX && Rt_EX!=0 && (Rt_EX==Rs_ID || Rt_EX==Rt_ID).
- Response: IF_stall=1, PC_Write=0, ID_EX_Bubble=1.

FP hazard (state FP_BUSY only):
- Condition: the ID instruction is FP and any of the following holds:
  - Fs_ID==busy_dest;
  - Rt_ID==busy_dest;
  - Fd_ID==busy_dest (WAW);
  - the ID instruction is itself a mul/div (structural).
- Response: same outputs as a load-use stall.

Combined stall: stall = load-use OR FP hazard.

Flush:
- IF_Flush = (Branch_Taken || Jump_ID) && !stall.
- When stall is asserted, the flush is suppressed. The branch re-resolves after the stall with correct operands.

PC and bubble outputs when no stall: PC_Write=1 and ID_EX_Bubble=0.

State machine (2 states, registered):
- IDLE -> FP_BUSY when an FP mul/div is in ID and stall==0 (it issues this cycle). Actions:
  - latch busy_dest=Fd_ID;
  - load the counter with FP_MUL_LAT or FP_DIV_LAT.
- FP_BUSY: the counter decrements by 1 per cycle.
  - When the counter equals 1, go to IDLE on that edge. An FP mul/div cannot issue in this cycle because the structural hazard still holds.
- FP_Busy = (state==FP_BUSY).

Stall_Cnt:
- Increments on every posedge where stall==1.
- Saturates at 16'hFFFF with no wrap.

## Timing
- IF_stall, IF_Flush, PC_Write and ID_EX_Bubble are combinational from the inputs and the registered state.
- Load-use stall lasts exactly 1 cycle. On the next edge the bubble reaches EX and MemRead_EX drops.
- FP issue at edge N: FP_Busy is high from edge N through edge N+LAT.
  - It is low after edge N+LAT.
  - A dependent FP instruction issues at edge N+LAT+1 or later.
- Reset asserted (async, any time, including mid-FP_BUSY):
  - state=IDLE, counter=0, busy_dest=0, Stall_Cnt=0;
  - while Rst_n is low, outputs are forced to IF_stall=0, IF_Flush=1, PC_Write=0, ID_EX_Bubble=1, FP_Busy=0;
  - normal operation starts at the first posedge after Rst_n rises.
- Simultaneous load-use and FP hazard: one stall. Stall_Cnt increments by 1 only.
- Simultaneous Branch_Taken and Jump_ID: IF_Flush=1 for one cycle.
- Rt_EX==0: never a hazard. Register $zero is excluded.

## Configuration
FP_HAZARD_EN:
- Defined: FP decode, FP_BUSY state, counter and busy_dest are built exactly as described above.
- Undefined:
  - FP logic is compiled out;
  - the state stays IDLE;
  - FP_Busy is tied 0;
  - stall = load-use only;
  - the parameters are unused.

## Test plan
- Reset: hold Rst_n=0 for 3 cycles with Branch_Taken=1 -> IF_Flush=1, PC_Write=0, ID_EX_Bubble=1, Stall_Cnt=0. After release with idle inputs -> PC_Write=1, IF_Flush=0.
- Load-use: MemRead_EX=1, Rt_EX=5, Rs_ID=5 for one cycle -> IF_stall=1, PC_Write=0, ID_EX_Bubble=1 for exactly 1 cycle, Stall_Cnt=1. Repeat with Rt_EX=0 -> no stall.
- Branch vs stall: Branch_Taken=1 with no hazard -> IF_Flush=1. Branch_Taken=1 plus load-use on Rt_ID -> IF_Flush=0, IF_stall=1.
- FP div (FP_HAZARD_EN, FP_DIV_LAT=10): div.s with Fd=4 issues, next instruction add.s with Fs=4 -> stalled 10 cycles, issues on the 11th, FP_Busy high 10 cycles, Stall_Cnt=10.
- Structural: mul.s issues, then mul.s with unrelated registers in the next cycle -> stalled until FP_Busy falls (FP_MUL_LAT=4 gives 4 stall cycles).
- Reset mid-FP_BUSY: pulse Rst_n low at cycle 3 of a div -> FP_Busy=0 immediately. After release a dependent add.s proceeds with no stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow control for the IF/ID register: load-use stall, branch/jump flush, stall counter.
// Tracking of one in-flight FP mul/div (FP_BUSY state) is built only when FP_HAZARD_EN is defined.
module pipe_hazard_ctrl #(
   parameter int FP_MUL_LAT = 4,
   parameter int FP_DIV_LAT = 10
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [5:0]  Op_code_ID,
   input  logic [5:0]  Funct_ID,
   input  logic [4:0]  Rs_ID,
   input  logic [4:0]  Rt_ID,
   input  logic [4:0]  Fs_ID,
   input  logic [4:0]  Fd_ID,
   input  logic        MemRead_EX,
   input  logic [4:0]  Rt_EX,
   input  logic        Branch_Taken,
   input  logic        Jump_ID,
   output logic        IF_stall,
   output logic        IF_Flush,
   output logic        PC_Write,
   output logic        ID_EX_Bubble,
   output logic        FP_Busy,
   output logic [15:0] Stall_Cnt
);

   typedef enum logic {IDLE, FP_BUSY} state_t;

   logic        w_loadUse;
   logic        w_fpHazard;
   logic        w_stall;
   logic        w_fpBusy;
   logic [15:0] r_stallCnt;

   // $zero is never a real producer, so a load into it cannot create a hazard
   assign w_loadUse = MemRead_EX && (Rt_EX != 5'd0) &&
                      ((Rt_EX == Rs_ID) || (Rt_EX == Rt_ID));

`ifdef FP_HAZARD_EN
   state_t     r_state;
   state_t     w_nextState;
   logic [3:0] r_count;
   logic [3:0] w_nextCount;
   logic [4:0] r_busyDest;
   logic [4:0] w_nextBusyDest;
   logic       w_isFp;
   logic       w_isMulDiv;

   assign w_isFp     = (Op_code_ID == 6'h11);
   assign w_isMulDiv = w_isFp && ((Funct_ID == 6'h02) || (Funct_ID == 6'h03));

   // Any mul/div in ID while busy is a structural conflict, regardless of registers
   assign w_fpHazard = (r_state == FP_BUSY) && w_isFp &&
                       ((Fs_ID == r_busyDest) || (Rt_ID == r_busyDest) ||
                        (Fd_ID == r_busyDest) || w_isMulDiv);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state    <= IDLE;
         r_count    <= 4'd0;
         r_busyDest <= 5'd0;
      end else begin
         r_state    <= w_nextState;
         r_count    <= w_nextCount;
         r_busyDest <= w_nextBusyDest;
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_nextCount    = r_count;
      w_nextBusyDest = r_busyDest;
      case (r_state)
         IDLE: begin
            if (w_isMulDiv && !w_stall) begin
               w_nextState    = FP_BUSY;
               w_nextBusyDest = Fd_ID;
               w_nextCount    = (Funct_ID == 6'h02) ? 4'(FP_MUL_LAT) : 4'(FP_DIV_LAT);
            end
         end
         FP_BUSY: begin
            if (r_count == 4'd1) begin
               w_nextState = IDLE;
               w_nextCount = 4'd0;
            end else begin
               w_nextCount = r_count - 4'd1;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCount = 4'd0;
         end
      endcase
   end

   assign w_fpBusy = (r_state == FP_BUSY);
`else
   logic w_unusedFp;

   // FP fields and latency parameters have no effect in this build
   assign w_unusedFp = ^{Op_code_ID, Funct_ID, Fs_ID, Fd_ID,
                         4'(FP_MUL_LAT), 4'(FP_DIV_LAT)};
   assign w_fpHazard = 1'b0;
   assign w_fpBusy   = 1'b0;
`endif

   assign w_stall = w_loadUse || w_fpHazard;

   // Reset forces a safe pipeline: PC frozen, IF/ID flushed, NOP into ID/EX
   always_comb begin
      IF_stall     = w_stall;
      IF_Flush     = (Branch_Taken || Jump_ID) && !w_stall;
      PC_Write     = !w_stall;
      ID_EX_Bubble = w_stall;
      FP_Busy      = w_fpBusy;
      if (!Rst_n) begin
         IF_stall     = 1'b0;
         IF_Flush     = 1'b1;
         PC_Write     = 1'b0;
         ID_EX_Bubble = 1'b1;
         FP_Busy      = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_stallCnt <= 16'd0;
      end else if (w_stall && (r_stallCnt != 16'hFFFF)) begin
         r_stallCnt <= r_stallCnt + 16'd1;
      end
   end

   assign Stall_Cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; FP scenarios run only when FP_HAZARD_EN is defined.
module tb_pipe_hazard_ctrl;

   logic        Clk;
   logic        Rst_n;
   logic [5:0]  Op_code_ID;
   logic [5:0]  Funct_ID;
   logic [4:0]  Rs_ID;
   logic [4:0]  Rt_ID;
   logic [4:0]  Fs_ID;
   logic [4:0]  Fd_ID;
   logic        MemRead_EX;
   logic [4:0]  Rt_EX;
   logic        Branch_Taken;
   logic        Jump_ID;
   logic        IF_stall;
   logic        IF_Flush;
   logic        PC_Write;
   logic        ID_EX_Bubble;
   logic        FP_Busy;
   logic [15:0] Stall_Cnt;

   int errors = 0;
   int checks = 0;

   // Control bundle {IF_stall, IF_Flush, PC_Write, ID_EX_Bubble, FP_Busy}
   logic [4:0] ctrl;
   assign ctrl = {IF_stall, IF_Flush, PC_Write, ID_EX_Bubble, FP_Busy};

   localparam logic [4:0] C_RUN   = 5'b00100;
   localparam logic [4:0] C_FLUSH = 5'b01100;
   localparam logic [4:0] C_STALL = 5'b10010;
   localparam logic [4:0] C_RESET = 5'b01010;
   localparam logic [4:0] C_BUSYS = 5'b10011;
   localparam logic [4:0] C_BUSYR = 5'b00101;

   pipe_hazard_ctrl #(.FP_MUL_LAT(4), .FP_DIV_LAT(10)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Op_code_ID(Op_code_ID), .Funct_ID(Funct_ID),
      .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Fs_ID(Fs_ID), .Fd_ID(Fd_ID),
      .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Branch_Taken(Branch_Taken),
      .Jump_ID(Jump_ID), .IF_stall(IF_stall), .IF_Flush(IF_Flush),
      .PC_Write(PC_Write), .ID_EX_Bubble(ID_EX_Bubble), .FP_Busy(FP_Busy),
      .Stall_Cnt(Stall_Cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clear_inputs();
      Op_code_ID = 6'd0; Funct_ID = 6'd0; Rs_ID = 5'd0; Rt_ID = 5'd0;
      Fs_ID = 5'd0; Fd_ID = 5'd0; MemRead_EX = 1'b0; Rt_EX = 5'd0;
      Branch_Taken = 1'b0; Jump_ID = 1'b0;
   endtask

   // Inputs change at posedge+1; comparisons happen at the following negedge
   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      Rst_n = 1'b0;
      next_cycle();
      Rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      Rst_n = 1'b0;
      Branch_Taken = 1'b1;
      MemRead_EX = 1'b1; Rt_EX = 5'd5; Rs_ID = 5'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         checks++;
         if (ctrl !== C_RESET) begin
            errors++;
            $display("[TB] FAIL reset_ctrl[%0d]: got %b expected %b", i, ctrl, C_RESET);
         end
      end
      checks++;
      if (Stall_Cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_cnt: got %0d expected 0", Stall_Cnt);
      end
      next_cycle();
      clear_inputs();
      Rst_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL reset_release: got %b expected %b", ctrl, C_RUN);
      end
      next_cycle();
      checks++;
      if (Stall_Cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_idle_cnt: got %0d expected 0", Stall_Cnt);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      MemRead_EX = 1'b1; Rt_EX = 5'd5; Rs_ID = 5'd5;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_STALL) begin
         errors++;
         $display("[TB] FAIL loaduse_stall: got %b expected %b", ctrl, C_STALL);
      end
      next_cycle();
      MemRead_EX = 1'b0;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL loaduse_release: got %b expected %b", ctrl, C_RUN);
      end
      checks++;
      if (Stall_Cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL loaduse_cnt: got %0d expected 1", Stall_Cnt);
      end
      next_cycle();
      MemRead_EX = 1'b1; Rt_EX = 5'd0; Rs_ID = 5'd0; Rt_ID = 5'd0;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL zero_reg_ctrl: got %b expected %b", ctrl, C_RUN);
      end
      next_cycle();
      clear_inputs();
      MemRead_EX = 1'b1; Rt_EX = 5'd9; Rs_ID = 5'd3; Rt_ID = 5'd4;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL loaduse_nomatch: got %b expected %b", ctrl, C_RUN);
      end
      checks++;
      if (Stall_Cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL zero_reg_cnt: got %0d expected 1", Stall_Cnt);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_branch_vs_stall();
      do_reset();
      Branch_Taken = 1'b1;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_FLUSH) begin
         errors++;
         $display("[TB] FAIL branch_flush: got %b expected %b", ctrl, C_FLUSH);
      end
      next_cycle();
      MemRead_EX = 1'b1; Rt_EX = 5'd7; Rt_ID = 5'd7;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_STALL) begin
         errors++;
         $display("[TB] FAIL branch_suppressed: got %b expected %b", ctrl, C_STALL);
      end
      next_cycle();
      clear_inputs();
      Branch_Taken = 1'b1; Jump_ID = 1'b1;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_FLUSH) begin
         errors++;
         $display("[TB] FAIL branch_jump_flush: got %b expected %b", ctrl, C_FLUSH);
      end
      checks++;
      if (Stall_Cnt !== 16'd1) begin
         errors++;
         $display("[TB] FAIL branch_cnt: got %0d expected 1", Stall_Cnt);
      end
      next_cycle();
      clear_inputs();
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL jump_one_cycle: got %b expected %b", ctrl, C_RUN);
      end
      next_cycle();
   endtask

`ifdef FP_HAZARD_EN
   task automatic test_fp_div();
      do_reset();
      Op_code_ID = 6'h11; Funct_ID = 6'h03; Fd_ID = 5'd4; Fs_ID = 5'd1; Rt_ID = 5'd2;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL div_issue: got %b expected %b", ctrl, C_RUN);
      end
      next_cycle();
      Funct_ID = 6'h00; Fs_ID = 5'd4; Rt_ID = 5'd6; Fd_ID = 5'd8;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         checks++;
         if (ctrl !== C_BUSYS) begin
            errors++;
            $display("[TB] FAIL div_dep_stall[%0d]: got %b expected %b", i, ctrl, C_BUSYS);
         end
         next_cycle();
      end
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL div_dep_issue: got %b expected %b", ctrl, C_RUN);
      end
      checks++;
      if (Stall_Cnt !== 16'd10) begin
         errors++;
         $display("[TB] FAIL div_cnt: got %0d expected 10", Stall_Cnt);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_fp_mul_struct();
      do_reset();
      Op_code_ID = 6'h11; Funct_ID = 6'h02; Fd_ID = 5'd10; Fs_ID = 5'd11; Rt_ID = 5'd12;
      next_cycle();
      Fd_ID = 5'd20; Fs_ID = 5'd21; Rt_ID = 5'd22;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         checks++;
         if (ctrl !== C_BUSYS) begin
            errors++;
            $display("[TB] FAIL mul_struct_stall[%0d]: got %b expected %b", i, ctrl, C_BUSYS);
         end
         next_cycle();
      end
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL mul_struct_issue: got %b expected %b", ctrl, C_RUN);
      end
      checks++;
      if (Stall_Cnt !== 16'd4) begin
         errors++;
         $display("[TB] FAIL mul_struct_cnt: got %0d expected 4", Stall_Cnt);
      end
      next_cycle();
      clear_inputs();
      @(negedge Clk);
      checks++;
      if (ctrl !== C_BUSYR) begin
         errors++;
         $display("[TB] FAIL mul_second_busy: got %b expected %b", ctrl, C_BUSYR);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_fp();
      do_reset();
      Op_code_ID = 6'h11; Funct_ID = 6'h03; Fd_ID = 5'd4; Fs_ID = 5'd1; Rt_ID = 5'd2;
      next_cycle();
      Funct_ID = 6'h00; Fs_ID = 5'd4; Rt_ID = 5'd6; Fd_ID = 5'd8;
      next_cycle();
      next_cycle();
      #1;
      Rst_n = 1'b0;
      #1;
      checks++;
      if (ctrl !== C_RESET) begin
         errors++;
         $display("[TB] FAIL midfp_reset_ctrl: got %b expected %b", ctrl, C_RESET);
      end
      checks++;
      if (Stall_Cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL midfp_reset_cnt: got %0d expected 0", Stall_Cnt);
      end
      next_cycle();
      Rst_n = 1'b1;
      @(negedge Clk);
      checks++;
      if (ctrl !== C_RUN) begin
         errors++;
         $display("[TB] FAIL midfp_dep_proceeds: got %b expected %b", ctrl, C_RUN);
      end
      next_cycle();
      clear_inputs();
      checks++;
      if (Stall_Cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL midfp_after_cnt: got %0d expected 0", Stall_Cnt);
      end
   endtask
`else
   task automatic test_fp_disabled();
      do_reset();
      Op_code_ID = 6'h11; Funct_ID = 6'h03; Fd_ID = 5'd4; Fs_ID = 5'd1; Rt_ID = 5'd2;
      next_cycle();
      Funct_ID = 6'h02; Fs_ID = 5'd4; Rt_ID = 5'd6; Fd_ID = 5'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         checks++;
         if (ctrl !== C_RUN) begin
            errors++;
            $display("[TB] FAIL fp_off_nostall[%0d]: got %b expected %b", i, ctrl, C_RUN);
         end
         next_cycle();
      end
      checks++;
      if (Stall_Cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL fp_off_cnt: got %0d expected 0", Stall_Cnt);
      end
      clear_inputs();
   endtask
`endif

   initial begin
      clear_inputs();
      Rst_n = 1'b0;
      test_reset();
      test_load_use();
      test_branch_vs_stall();
`ifdef FP_HAZARD_EN
      test_fp_div();
      test_fp_mul_struct();
      test_reset_mid_fp();
`else
      test_fp_disabled();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
